// File: rtl/bf16_issue_arbiter.sv
// bf16_issue_arbiter
// Shares one bf16_unit scalar datapath between two requesters. Commands are
// granted round-robin (one per cycle), registered onto the unit inputs, tracked
// through a valid/tag shift register that matches the unit's pipeline latency,
// and their results are captured into a response FIFO. Issue is credit-limited
// so every in-flight result is guaranteed a FIFO slot.
//
// Ports:
//   clk_i, reset_i             clock, asynchronous active-high reset
//   reqN_valid_i/reqN_ready_o  requester N command handshake (N = 0, 1)
//   reqN_funct5_i              operation code
//   reqN_op1_i..reqN_op3_i     bf16 operands
//   reqN_tag_i                 tag returned with the result
//   unit_in1_o..unit_in3_o     registered operands to bf16_unit
//   unit_funct5_o              registered operation code to bf16_unit
//   unit_result_i              result from bf16_unit
//   rsp_valid_o/rsp_ready_i    response FIFO head handshake
//   rsp_data_o, rsp_tag_o      head result and its tag
//   rsp_src_o                  0 = requester 0, 1 = requester 1
//   busy_o                     operations in flight or buffered
module bf16_issue_arbiter #(
    parameter int unsigned LATENCY = 17,
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned TAG_W   = 4,
    parameter logic [4:0]  IDLE_F5 = 5'b00000
) (
    input  logic             clk_i,
    input  logic             reset_i,

    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [4:0]       req0_funct5_i,
    input  logic [15:0]      req0_op1_i,
    input  logic [15:0]      req0_op2_i,
    input  logic [15:0]      req0_op3_i,
    input  logic [TAG_W-1:0] req0_tag_i,

    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [4:0]       req1_funct5_i,
    input  logic [15:0]      req1_op1_i,
    input  logic [15:0]      req1_op2_i,
    input  logic [15:0]      req1_op3_i,
    input  logic [TAG_W-1:0] req1_tag_i,

    output logic [15:0]      unit_in1_o,
    output logic [15:0]      unit_in2_o,
    output logic [15:0]      unit_in3_o,
    output logic [4:0]       unit_funct5_o,
    input  logic [15:0]      unit_result_i,

    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [15:0]      rsp_data_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic             rsp_src_o,
    output logic             busy_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] FULL_C   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

    // Arbitration state and counters
    logic             rr_q;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] fifo_count_q, fifo_count_d;
    logic [CNT_W:0]   credits_used;
    logic             credit_ok;

    // Registered unit inputs
    logic [15:0] unit_in1_q, unit_in2_q, unit_in3_q;
    logic [4:0]  unit_funct5_q;

    // Tracking shift register. Stage 0 is loaded on the issue edge; the unit's
    // result for that issue becomes visible LATENCY edges later and is sampled
    // on the edge after that, hence LATENCY+1 stages.
    logic [LATENCY:0]            sr_vld_q;
    logic [LATENCY:0]            sr_src_q;
    logic [LATENCY:0][TAG_W-1:0] sr_tag_q;

    // Response FIFO
    logic [15:0]      mem_data_q [DEPTH];
    logic [TAG_W-1:0] mem_tag_q  [DEPTH];
    logic             mem_src_q  [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;

    // Handshake / datapath controls
    logic             gnt0, gnt1;
    logic             xfer0, xfer1, xfer;
    logic [4:0]       iss_funct5;
    logic [15:0]      iss_op1, iss_op2, iss_op3;
    logic [TAG_W-1:0] iss_tag;
    logic             fifo_wr, fifo_rd;

    // ------------------------------------------------------------------
    // Credit and arbitration
    // ------------------------------------------------------------------
    assign credits_used = {1'b0, inflight_q} + {1'b0, fifo_count_q};
    assign credit_ok    = credits_used < DEPTH_C;

    // rr_q == 0 favours requester 0 when both are valid.
    assign gnt0 = req0_valid_i & (~req1_valid_i | ~rr_q);
    assign gnt1 = req1_valid_i & (~req0_valid_i |  rr_q);

    assign req0_ready_o = gnt0 & credit_ok & ~reset_i;
    assign req1_ready_o = gnt1 & credit_ok & ~reset_i;

    assign xfer0 = req0_valid_i & req0_ready_o;
    assign xfer1 = req1_valid_i & req1_ready_o;
    assign xfer  = xfer0 | xfer1;

    always_comb begin
        iss_funct5 = IDLE_F5;
        iss_op1    = 16'h0000;
        iss_op2    = 16'h0000;
        iss_op3    = 16'h0000;
        iss_tag    = '0;
        if (xfer1) begin
            iss_funct5 = req1_funct5_i;
            iss_op1    = req1_op1_i;
            iss_op2    = req1_op2_i;
            iss_op3    = req1_op3_i;
            iss_tag    = req1_tag_i;
        end else if (xfer0) begin
            iss_funct5 = req0_funct5_i;
            iss_op1    = req0_op1_i;
            iss_op2    = req0_op2_i;
            iss_op3    = req0_op3_i;
            iss_tag    = req0_tag_i;
        end
    end

    // ------------------------------------------------------------------
    // Completion and FIFO control
    // ------------------------------------------------------------------
    assign fifo_wr = sr_vld_q[LATENCY];
    assign fifo_rd = rsp_ready_i & (fifo_count_q != '0);

    always_comb begin
        inflight_d = inflight_q;
        unique case ({xfer, fifo_wr})
            2'b10:   inflight_d = inflight_q + ONE_C;
            2'b01:   inflight_d = inflight_q - ONE_C;
            default: inflight_d = inflight_q;
        endcase
    end

    always_comb begin
        fifo_count_d = fifo_count_q;
        unique case ({fifo_wr, fifo_rd})
            2'b10:   fifo_count_d = fifo_count_q + ONE_C;
            2'b01:   fifo_count_d = fifo_count_q - ONE_C;
            default: fifo_count_d = fifo_count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rr_q          <= 1'b0;
            inflight_q    <= '0;
            fifo_count_q  <= '0;
            unit_in1_q    <= 16'h0000;
            unit_in2_q    <= 16'h0000;
            unit_in3_q    <= 16'h0000;
            unit_funct5_q <= IDLE_F5;
            sr_vld_q      <= '0;
            sr_src_q      <= '0;
            sr_tag_q      <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            if (xfer) begin
                rr_q <= xfer0;
            end
            inflight_q    <= inflight_d;
            fifo_count_q  <= fifo_count_d;
            unit_in1_q    <= iss_op1;
            unit_in2_q    <= iss_op2;
            unit_in3_q    <= iss_op3;
            unit_funct5_q <= iss_funct5;
            sr_vld_q      <= {sr_vld_q[LATENCY-1:0], xfer};
            sr_src_q      <= {sr_src_q[LATENCY-1:0], xfer1};
            sr_tag_q      <= {sr_tag_q[LATENCY-1:0], iss_tag};
            if (fifo_wr) begin
                wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (fifo_rd) begin
                rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Storage is not reset; occupancy is tracked by fifo_count_q.
    always_ff @(posedge clk_i) begin
        if (fifo_wr) begin
            mem_data_q[wr_ptr_q] <= unit_result_i;
            mem_tag_q[wr_ptr_q]  <= sr_tag_q[LATENCY];
            mem_src_q[wr_ptr_q]  <= sr_src_q[LATENCY];
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign unit_in1_o    = unit_in1_q;
    assign unit_in2_o    = unit_in2_q;
    assign unit_in3_o    = unit_in3_q;
    assign unit_funct5_o = unit_funct5_q;

    assign rsp_valid_o = fifo_count_q != '0;
    assign rsp_data_o  = mem_data_q[rd_ptr_q];
    assign rsp_tag_o   = mem_tag_q[rd_ptr_q];
    assign rsp_src_o   = mem_src_q[rd_ptr_q];
    assign busy_o      = (inflight_q != '0) | (fifo_count_q != '0);

    // The credit check must make a write into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
        !(fifo_wr && (fifo_count_q == FULL_C) && !fifo_rd));

    a_one_ready: assert property (@(posedge clk_i) disable iff (reset_i)
        !(req0_ready_o && req1_ready_o));

endmodule
